dm_arbiter: RTL and testbench

Sequencing controller and arbiter for the single-port data memory of the MEM stage. It shares the memory between two requesters: the pipeline MEM stage, which has priority, and a loader/debug port used to preload or inspect data memory. It inserts a configurable number of wait states per access. While the pipeline's access is in flight, it stalls the pipeline so the MEM/WB register captures valid data.

---
 rtl/dm_arb_pkg.sv | 15 +
 rtl/dm_arb_select.sv | 37 +++
 rtl/dm_arbiter.sv | 109 ++++++++++
 tb/tb_dm_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arbiter shared types: FSM states, grant encoding, counter width.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic GNT_PIPE = 1'b0;
  localparam logic GNT_LOAD = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dm_arb_select.sv
// Grant decision between pipeline and loader, with loader
// anti-starvation counter.
module dm_arb_select
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_req,
  input  logic l_req,
  input  logic grant_strobe,
  output logic gnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             l_win;

  // Pipeline has priority until the loader has waited LIMIT grants.
  assign l_win = l_req && (!p_req || starve_cnt == LIMIT);
  assign gnt   = l_win ? GNT_LOAD : GNT_PIPE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_strobe) begin
      if (gnt == GNT_LOAD || !l_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data memory sequencer: arbitrates pipeline and loader,
// inserts wait states, and stalls the pipeline while its access runs.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ack,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_read,
  output logic        dm_write,
  input  logic [31:0] dm_rdata
);

  state_t           state;
  logic             gnt;
  logic             gnt_q;
  logic             we_q;
  logic             strobe;
  logic [CNT_W-1:0] wait_cnt;

  assign strobe = (state == S_IDLE) && (p_req || l_req);

  dm_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_req       (p_req),
    .l_req       (l_req),
    .grant_strobe(strobe),
    .gnt         (gnt)
  );

  assign p_stall = p_req &&
    !(state == S_RESP && gnt_q == GNT_PIPE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt_q    <= GNT_PIPE;
      we_q     <= 1'b0;
      wait_cnt <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_read  <= 1'b0;
      dm_write <= 1'b0;
      p_rdata  <= '0;
      l_rdata  <= '0;
      l_ack    <= 1'b0;
    end else begin
      l_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (strobe) begin
            state    <= S_ACCESS;
            gnt_q    <= gnt;
            wait_cnt <= CNT_W'(WAIT_STATES);
            if (gnt == GNT_LOAD) begin
              we_q     <= l_we;
              dm_addr  <= l_addr;
              dm_wdata <= l_wdata;
              dm_read  <= !l_we;
              dm_write <= l_we;
            end else begin
              we_q     <= p_we;
              dm_addr  <= p_addr;
              dm_wdata <= p_wdata;
              dm_read  <= !p_we;
              dm_write <= p_we;
            end
          end
        end
        S_ACCESS: begin
          if (wait_cnt == '0) begin
            state    <= S_RESP;
            dm_read  <= 1'b0;
            dm_write <= 1'b0;
            l_ack    <= (gnt_q == GNT_LOAD);
            if (!we_q) begin
              if (gnt_q == GNT_LOAD) l_rdata <= dm_rdata;
              else                   p_rdata <= dm_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: three instances with
// WAIT_STATES 1, 3 and 0, each with its own memory model.
module tb_dm_arbiter;

  typedef struct {
    int          inst;
    int          cyc;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n    [3];
  logic        p_req    [3];
  logic        p_we     [3];
  logic [31:0] p_addr   [3];
  logic [31:0] p_wdata  [3];
  logic [31:0] p_rdata  [3];
  logic        p_stall  [3];
  logic        l_req    [3];
  logic        l_we     [3];
  logic [31:0] l_addr   [3];
  logic [31:0] l_wdata  [3];
  logic [31:0] l_rdata  [3];
  logic        l_ack    [3];
  logic [31:0] dm_addr  [3];
  logic [31:0] dm_wdata [3];
  logic        dm_read  [3];
  logic        dm_write [3];
  logic [31:0] dm_rdata [3];

  int   cyc  = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t pq[$];
  exp_t lq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic int ws(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_pipe(int k);
    exp_t e;
    vecs++;
    if (pq.size() == 0) begin
      errs++;
      $display("FAIL pipe_resp: unexpected release inst %0d cyc %0d", k, cyc);
    end else begin
      e = pq.pop_front();
      if (e.inst != k || e.cyc != cyc || (e.chk && p_rdata[k] !== e.data)) begin
        errs++;
        $display("FAIL pipe_resp: got inst %0d cyc %0d data %h, want inst %0d cyc %0d data %h",
                 k, cyc, p_rdata[k], e.inst, e.cyc, e.data);
      end
    end
  endtask

  task automatic check_load(int k);
    exp_t e;
    vecs++;
    if (lq.size() == 0) begin
      errs++;
      $display("FAIL load_ack: unexpected ack inst %0d cyc %0d", k, cyc);
    end else begin
      e = lq.pop_front();
      if (e.inst != k || e.cyc != cyc || (e.chk && l_rdata[k] !== e.data)) begin
        errs++;
        $display("FAIL load_ack: got inst %0d cyc %0d data %h, want inst %0d cyc %0d data %h",
                 k, cyc, l_rdata[k], e.inst, e.cyc, e.data);
      end
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [31:0] mem [256];

    dm_arbiter #(
      .WAIT_STATES ((i == 0) ? 1 : (i == 1) ? 3 : 0),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[i]),
      .p_req   (p_req[i]),
      .p_we    (p_we[i]),
      .p_addr  (p_addr[i]),
      .p_wdata (p_wdata[i]),
      .p_rdata (p_rdata[i]),
      .p_stall (p_stall[i]),
      .l_req   (l_req[i]),
      .l_we    (l_we[i]),
      .l_addr  (l_addr[i]),
      .l_wdata (l_wdata[i]),
      .l_rdata (l_rdata[i]),
      .l_ack   (l_ack[i]),
      .dm_addr (dm_addr[i]),
      .dm_wdata(dm_wdata[i]),
      .dm_read (dm_read[i]),
      .dm_write(dm_write[i]),
      .dm_rdata(dm_rdata[i])
    );

    always @(posedge clk)
      if (dm_write[i]) mem[dm_addr[i][7:0]] <= dm_wdata[i];

    assign dm_rdata[i] = mem[dm_addr[i][7:0]];

    always @(negedge clk) begin
      if (rst_n[i] && p_req[i] && !p_stall[i]) check_pipe(i);
      if (l_ack[i]) check_load(i);
    end
  end

  task automatic pipe_op(int k, bit we, logic [31:0] a, logic [31:0] d,
                         logic [31:0] exp_d);
    @(posedge clk);
    #1;
    p_req[k] = 1'b1;
    p_we[k] = we;
    p_addr[k] = a;
    p_wdata[k] = d;
    pq.push_back('{k, cyc + ws(k) + 2, !we, exp_d});
    repeat (ws(k) + 3) @(posedge clk);
    #1 p_req[k] = 1'b0;
  endtask

  task automatic load_op(int k, bit we, logic [31:0] a, logic [31:0] d,
                         logic [31:0] exp_d);
    @(posedge clk);
    #1;
    l_req[k] = 1'b1;
    l_we[k] = we;
    l_addr[k] = a;
    l_wdata[k] = d;
    lq.push_back('{k, cyc + ws(k) + 2, !we, exp_d});
    repeat (ws(k) + 3) @(posedge clk);
    #1 l_req[k] = 1'b0;
  endtask

  initial begin
    int c;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      p_req[k] = 1'b0;
      p_we[k] = 1'b0;
      p_addr[k] = '0;
      p_wdata[k] = '0;
      l_req[k] = 1'b0;
      l_we[k] = 1'b0;
      l_addr[k] = '0;
      l_wdata[k] = '0;
    end
    p_req[0] = 1'b1;
    l_req[0] = 1'b1;
    #12;
    chk("rst_dm_read", dm_read[0], 0);
    chk("rst_dm_write", dm_write[0], 0);
    chk("rst_l_ack", l_ack[0], 0);
    chk("rst_p_rdata", p_rdata[0], 0);
    chk("rst_l_rdata", l_rdata[0], 0);
    chk("rst_p_stall", p_stall[0], 1);
    chk("rst_dm_addr", dm_addr[0], 0);
    p_req[0] = 1'b0;
    l_req[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    pipe_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);

    // Pipeline read with cycle-by-cycle strobe checks
    @(posedge clk);
    #1;
    c = cyc;
    p_req[0] = 1'b1;
    p_we[0] = 1'b0;
    p_addr[0] = 32'h10;
    pq.push_back('{0, c + 3, 1'b1, 32'hDEADBEEF});
    @(negedge clk);
    chk("rd_c0_stall", p_stall[0], 1);
    chk("rd_c0_read", dm_read[0], 0);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      chk("rd_acc_stall", p_stall[0], 1);
      chk("rd_acc_read", dm_read[0], 1);
    end
    @(negedge clk);
    chk("rd_c3_stall", p_stall[0], 0);
    chk("rd_c3_read", dm_read[0], 0);
    chk("rd_c3_rdata", p_rdata[0], 32'hDEADBEEF);
    @(posedge clk);
    #1 p_req[0] = 1'b0;

    load_op(0, 1'b1, 32'h40, 32'h12345678, 32'h0);
    pipe_op(0, 1'b0, 32'h40, 32'h0, 32'h12345678);

    // Contention: both held for ten back-to-back grants
    @(posedge clk);
    #1;
    c = cyc;
    p_req[0] = 1'b1;
    p_we[0] = 1'b0;
    p_addr[0] = 32'h10;
    l_req[0] = 1'b1;
    l_we[0] = 1'b0;
    l_addr[0] = 32'h40;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9)
        lq.push_back('{0, c + 3 + 4 * k, 1'b1, 32'h12345678});
      else
        pq.push_back('{0, c + 3 + 4 * k, 1'b1, 32'hDEADBEEF});
    end
    repeat (40) @(posedge clk);
    #1;
    p_req[0] = 1'b0;
    l_req[0] = 1'b0;

    // Reset in the second ACCESS cycle of a loader write
    @(posedge clk);
    #1;
    l_req[1] = 1'b1;
    l_we[1] = 1'b1;
    l_addr[1] = 32'h80;
    l_wdata[1] = 32'hBAD0BAD0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mid_pre_write", dm_write[1], 1);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_write_drop", dm_write[1], 0);
    chk("rst_mid_no_ack", l_ack[1], 0);
    l_req[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle_write", dm_write[1], 0);
    chk("rst_mid_idle_read", dm_read[1], 0);
    chk("rst_mid_idle_ack", l_ack[1], 0);
    load_op(1, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0);
    load_op(1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D);

    // Zero wait states: write then immediate read
    @(posedge clk);
    #1;
    p_req[2] = 1'b1;
    p_we[2] = 1'b1;
    p_addr[2] = 32'h20;
    p_wdata[2] = 32'h55AA33CC;
    pq.push_back('{2, cyc + 2, 1'b0, 32'h0});
    @(negedge clk);
    chk("w0_c0_stall", p_stall[2], 1);
    chk("w0_c0_write", dm_write[2], 0);
    @(negedge clk);
    chk("w0_c1_write", dm_write[2], 1);
    @(negedge clk);
    chk("w0_c2_write", dm_write[2], 0);
    chk("w0_c2_stall", p_stall[2], 0);
    @(posedge clk);
    #1;
    p_we[2] = 1'b0;
    pq.push_back('{2, cyc + 2, 1'b1, 32'h55AA33CC});
    @(negedge clk);
    chk("w0_c3_read", dm_read[2], 0);
    @(negedge clk);
    chk("w0_c4_read", dm_read[2], 1);
    @(posedge clk);
    @(posedge clk);
    #1 p_req[2] = 1'b0;

    repeat (4) @(posedge clk);
    chk("pipe_leftover", pq.size(), 0);
    chk("load_leftover", lq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
